// File: rtl/isa_pkg.sv
// ISA definitions for the 16-bit pipeline: opcodes, ALU codes, field positions,
// decode-stage FSM states and small opcode classification helpers.
package isa_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_NOT  = 5'b00101;
    localparam logic [4:0] OP_MOV  = 5'b00110;
    localparam logic [4:0] OP_LDM  = 5'b01000;
    localparam logic [4:0] OP_LDD  = 5'b01001;
    localparam logic [4:0] OP_STD  = 5'b01010;
    localparam logic [4:0] OP_IADD = 5'b01011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_NOT   = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;

    localparam int OPC_LSB  = 11;
    localparam int RDST_LSB = 8;
    localparam int RSRC_LSB = 5;

    typedef enum logic {ST_DECODE, ST_WAIT_IMM} state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       use_imm;
    } ctrl_t;

    function automatic logic is_two_word(input logic [4:0] op);
        return (op == OP_LDM) || (op == OP_IADD);
    endfunction

    function automatic logic reads_src(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_LDD, OP_STD, OP_IADD};
    endfunction

    function automatic logic reads_dst(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_STD, OP_IADD};
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode-to-control decoder; undefined opcodes yield all-zero control.
module ctrl_decode
    import isa_pkg::*;
(
    input  logic [4:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_ADD:  begin ctrl.alu_op = ALU_ADD;   ctrl.reg_write = 1'b1; end
            OP_SUB:  begin ctrl.alu_op = ALU_SUB;   ctrl.reg_write = 1'b1; end
            OP_AND:  begin ctrl.alu_op = ALU_AND;   ctrl.reg_write = 1'b1; end
            OP_OR:   begin ctrl.alu_op = ALU_OR;    ctrl.reg_write = 1'b1; end
            OP_NOT:  begin ctrl.alu_op = ALU_NOT;   ctrl.reg_write = 1'b1; end
            OP_MOV:  begin ctrl.alu_op = ALU_PASSB; ctrl.reg_write = 1'b1; end
            OP_LDM:  begin ctrl.alu_op = ALU_PASSB; ctrl.reg_write = 1'b1; ctrl.use_imm = 1'b1; end
            OP_IADD: begin ctrl.alu_op = ALU_ADD;   ctrl.reg_write = 1'b1; ctrl.use_imm = 1'b1; end
            OP_LDD:  begin ctrl.alu_op = ALU_PASSB; ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1; end
            OP_STD:  begin ctrl.mem_write = 1'b1; end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: regfile address decode, two-word instruction FSM, load-use stall,
// branch flush and the ID/EX pipeline register.
module decode_stage
    import isa_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr,
    input  logic              in_valid,
    input  logic              flush,
    input  logic              ex_mem_read,
    input  logic [ADDR_W-1:0] ex_rd,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dst_addr,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    output logic              stall,
    output logic              idex_valid,
    output logic [2:0]        idex_alu_op,
    output logic [ADDR_W-1:0] idex_rd,
    output logic [DATA_W-1:0] idex_op1,
    output logic [DATA_W-1:0] idex_op2,
    output logic [DATA_W-1:0] idex_imm,
    output logic              idex_use_imm,
    output logic              idex_reg_write,
    output logic              idex_mem_read,
    output logic              idex_mem_write
);

    state_t            state;
    logic [4:0]        opcode;
    logic [ADDR_W-1:0] rsrc, rdst;
    logic [4:0]        held_op;
    logic [ADDR_W-1:0] held_rd;
    logic [DATA_W-1:0] held_d1, held_d2;
    logic [4:0]        dec_op;
    logic              hazard;
    ctrl_t             ctrl;

    assign opcode   = instr[OPC_LSB +: 5];
    assign rdst     = instr[RDST_LSB +: ADDR_W];
    assign rsrc     = instr[RSRC_LSB +: ADDR_W];
    assign src_addr = rsrc;
    assign dst_addr = rdst;

    assign hazard = ex_mem_read && ((reads_src(opcode) && ex_rd == rsrc) ||
                                    (reads_dst(opcode) && ex_rd == rdst));
    assign stall  = (state == ST_DECODE) && in_valid && !flush && hazard;

    // While waiting for the immediate, control comes from the held first word.
    assign dec_op = (state == ST_WAIT_IMM) ? held_op : opcode;

    ctrl_decode u_ctrl (
        .opcode (dec_op),
        .ctrl   (ctrl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_DECODE;
            held_op        <= '0;
            held_rd        <= '0;
            held_d1        <= '0;
            held_d2        <= '0;
            idex_valid     <= 1'b0;
            idex_alu_op    <= '0;
            idex_rd        <= '0;
            idex_op1       <= '0;
            idex_op2       <= '0;
            idex_imm       <= '0;
            idex_use_imm   <= 1'b0;
            idex_reg_write <= 1'b0;
            idex_mem_read  <= 1'b0;
            idex_mem_write <= 1'b0;
        end else begin
            // Bubble unless one of the issue paths below overrides it.
            idex_valid     <= 1'b0;
            idex_alu_op    <= '0;
            idex_rd        <= '0;
            idex_op1       <= '0;
            idex_op2       <= '0;
            idex_imm       <= '0;
            idex_use_imm   <= 1'b0;
            idex_reg_write <= 1'b0;
            idex_mem_read  <= 1'b0;
            idex_mem_write <= 1'b0;
            if (flush) begin
                state <= ST_DECODE;
            end else if (state == ST_WAIT_IMM) begin
                if (in_valid) begin
                    idex_valid     <= 1'b1;
                    idex_alu_op    <= ctrl.alu_op;
                    idex_rd        <= held_rd;
                    idex_op1       <= held_d1;
                    idex_op2       <= held_d2;
                    idex_imm       <= instr;
                    idex_use_imm   <= 1'b1;
                    idex_reg_write <= ctrl.reg_write;
                    idex_mem_read  <= ctrl.mem_read;
                    idex_mem_write <= ctrl.mem_write;
                    state          <= ST_DECODE;
                end
            end else if (in_valid && !stall) begin
                if (is_two_word(opcode)) begin
                    held_op <= opcode;
                    held_rd <= rdst;
                    held_d1 <= read_data1;
                    held_d2 <= read_data2;
                    state   <= ST_WAIT_IMM;
                end else begin
                    idex_valid     <= 1'b1;
                    idex_alu_op    <= ctrl.alu_op;
                    idex_rd        <= rdst;
                    idex_op1       <= read_data1;
                    idex_op2       <= read_data2;
                    idex_use_imm   <= ctrl.use_imm;
                    idex_reg_write <= ctrl.reg_write;
                    idex_mem_read  <= ctrl.mem_read;
                    idex_mem_write <= ctrl.mem_write;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference model pushes the expected ID/EX
// contents at stimulus time; a monitor pops and compares after each posedge.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        in_valid, flush, ex_mem_read;
    logic [2:0]  ex_rd;
    logic [2:0]  src_addr, dst_addr;
    logic [15:0] read_data1, read_data2;
    logic        stall;
    logic        idex_valid;
    logic [2:0]  idex_alu_op, idex_rd;
    logic [15:0] idex_op1, idex_op2, idex_imm;
    logic        idex_use_imm, idex_reg_write, idex_mem_read, idex_mem_write;

    decode_stage dut (
        .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .flush(flush),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .src_addr(src_addr), .dst_addr(dst_addr),
        .read_data1(read_data1), .read_data2(read_data2), .stall(stall),
        .idex_valid(idex_valid), .idex_alu_op(idex_alu_op), .idex_rd(idex_rd),
        .idex_op1(idex_op1), .idex_op2(idex_op2), .idex_imm(idex_imm),
        .idex_use_imm(idex_use_imm), .idex_reg_write(idex_reg_write),
        .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [2:0]  alu;
        logic [2:0]  rd;
        logic [15:0] op1, op2, imm;
        logic        use_imm, rw, mr, mw;
    } exp_t;

    exp_t sb[$];
    int   n_run = 0;
    int   n_fail = 0;

    // reference model state
    logic        m_wait = 1'b0;
    logic [4:0]  h_op;
    logic [2:0]  h_rd;
    logic [15:0] h_d1, h_d2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] op, input logic [2:0] rd,
                                input logic [15:0] d1, input logic [15:0] d2);
        exp_t e;
        e = '{valid: 1'b1, alu: 3'd0, rd: rd, op1: d1, op2: d2, imm: 16'h0,
              use_imm: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0};
        case (op)
            5'd1:  begin e.alu = 3'd0; e.rw = 1'b1; end
            5'd2:  begin e.alu = 3'd1; e.rw = 1'b1; end
            5'd3:  begin e.alu = 3'd2; e.rw = 1'b1; end
            5'd4:  begin e.alu = 3'd3; e.rw = 1'b1; end
            5'd5:  begin e.alu = 3'd4; e.rw = 1'b1; end
            5'd6:  begin e.alu = 3'd5; e.rw = 1'b1; end
            5'd8:  begin e.alu = 3'd5; e.rw = 1'b1; end
            5'd9:  begin e.alu = 3'd5; e.rw = 1'b1; e.mr = 1'b1; end
            5'd10: begin e.mw = 1'b1; end
            5'd11: begin e.alu = 3'd0; e.rw = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic m_rs(input logic [4:0] op);
        return op == 5'd1 || op == 5'd2 || op == 5'd3 || op == 5'd4 || op == 5'd6 ||
               op == 5'd9 || op == 5'd10 || op == 5'd11;
    endfunction

    function automatic logic m_rd(input logic [4:0] op);
        return op == 5'd1 || op == 5'd2 || op == 5'd3 || op == 5'd4 || op == 5'd5 ||
               op == 5'd10 || op == 5'd11;
    endfunction

    task automatic step(input logic [15:0] w, input logic v, input logic f, input logic emr,
                        input logic [2:0] erd, input logic [15:0] d1, input logic [15:0] d2,
                        input logic r);
        exp_t       e;
        logic       es;
        logic [4:0] op;
        @(negedge clk);
        instr = w; in_valid = v; flush = f; ex_mem_read = emr; ex_rd = erd;
        read_data1 = d1; read_data2 = d2; rst = r;
        op = w[15:11];
        es = !m_wait && v && !f && emr &&
             ((m_rs(op) && erd == w[7:5]) || (m_rd(op) && erd == w[10:8]));
        #1;
        chk("stall", {31'd0, stall}, {31'd0, es});
        chk("src_addr", {29'd0, src_addr}, {29'd0, w[7:5]});
        chk("dst_addr", {29'd0, dst_addr}, {29'd0, w[10:8]});
        e = '{valid: 1'b0, alu: 3'd0, rd: 3'd0, op1: 16'h0, op2: 16'h0, imm: 16'h0,
              use_imm: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0};
        if (r) begin
            m_wait = 1'b0; h_op = '0; h_rd = '0; h_d1 = '0; h_d2 = '0;
        end else if (f) begin
            m_wait = 1'b0;
        end else if (m_wait) begin
            if (v) begin
                e = mk(h_op, h_rd, h_d1, h_d2);
                e.imm = w; e.use_imm = 1'b1;
                m_wait = 1'b0;
            end
        end else if (v && !es) begin
            if (op == 5'd8 || op == 5'd11) begin
                m_wait = 1'b1; h_op = op; h_rd = w[10:8]; h_d1 = d1; h_d2 = d2;
            end else begin
                e = mk(op, w[10:8], d1, d2);
            end
        end
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("idex_valid",  {31'd0, idex_valid},     {31'd0, e.valid});
            chk("idex_alu_op", {29'd0, idex_alu_op},    {29'd0, e.alu});
            chk("idex_rd",     {29'd0, idex_rd},        {29'd0, e.rd});
            chk("idex_op1",    {16'd0, idex_op1},       {16'd0, e.op1});
            chk("idex_op2",    {16'd0, idex_op2},       {16'd0, e.op2});
            chk("idex_imm",    {16'd0, idex_imm},       {16'd0, e.imm});
            chk("idex_use_imm",{31'd0, idex_use_imm},   {31'd0, e.use_imm});
            chk("idex_rw",     {31'd0, idex_reg_write}, {31'd0, e.rw});
            chk("idex_mr",     {31'd0, idex_mem_read},  {31'd0, e.mr});
            chk("idex_mw",     {31'd0, idex_mem_write}, {31'd0, e.mw});
        end
    end

    initial begin
        rst = 1'b1; instr = '0; in_valid = 1'b0; flush = 1'b0; ex_mem_read = 1'b0;
        ex_rd = '0; read_data1 = '0; read_data2 = '0;
        // reset wins even with a valid ADD presented
        step(16'h0940, 1, 0, 0, 0, 16'd5, 16'd7, 1);
        step(16'h0940, 1, 0, 0, 0, 16'd5, 16'd7, 0);          // ADD R1,R2
        step(16'h4300, 1, 0, 0, 0, 16'h0011, 16'h0022, 0);    // LDM R3
        step(16'h00AB, 1, 0, 0, 0, 16'hDEAD, 16'hBEEF, 0);    // immediate
        step(16'h0940, 1, 0, 1, 2, 16'd5, 16'd7, 0);          // load-use on rsrc
        step(16'h0940, 1, 0, 0, 2, 16'd5, 16'd7, 0);
        step(16'h4300, 1, 0, 0, 0, 16'h0001, 16'h0002, 0);    // LDM then flush
        step(16'h00AB, 1, 1, 0, 0, 16'h0003, 16'h0004, 0);
        step(16'h0940, 1, 0, 0, 0, 16'h0009, 16'h000A, 0);
        step(16'h5A40, 1, 0, 0, 0, 16'h0100, 16'h0200, 0);    // IADD, then reset in WAIT_IMM
        step(16'h1234, 1, 0, 0, 0, 16'h0000, 16'h0000, 1);
        step(16'h0940, 1, 0, 0, 0, 16'h0055, 16'h0066, 0);    // fresh first word
        step(16'hFD20, 1, 0, 1, 1, 16'h0777, 16'h0888, 0);    // undefined opcode, no stall
        step(16'h0940, 0, 0, 0, 0, 16'h0001, 16'h0001, 0);    // idle
        step(16'h5A40, 1, 0, 0, 0, 16'h0A0A, 16'h0B0B, 0);    // IADD with gap
        step(16'h0000, 0, 0, 1, 2, 16'h0000, 16'h0000, 0);
        step(16'h0940, 1, 0, 1, 2, 16'h0000, 16'h0000, 0);    // imm word: stall forced 0
        step(16'h4C40, 1, 0, 0, 0, 16'h0033, 16'h0044, 0);    // LDD R4,[R2]
        step(16'h5320, 1, 0, 1, 3, 16'h0010, 16'h0020, 0);    // STD hazard on rdst
        step(16'h5320, 1, 0, 0, 3, 16'h0010, 16'h0020, 0);
        step(16'h2AC0, 1, 0, 1, 6, 16'h0050, 16'h0060, 0);    // NOT ignores rsrc
        step(16'h0940, 1, 1, 1, 2, 16'h0050, 16'h0060, 0);    // flush beats stall
        for (int i = 0; i < 300; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[15:11] = ($urandom_range(0, 1) == 0) ? 5'd8 : 5'd11;
            step(w, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0, 3'($urandom), 16'($urandom), 16'($urandom),
                 $urandom_range(0, 29) == 0);
        end
        @(posedge clk);
        #2;
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
